// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending scoreboard and a sequenced bulk-clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_ready1,
  output logic              rd_ready2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ok,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic        ZR   = (ZERO_REG != 0);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   cnt;
  logic              wr_go, alloc_go, inc, dec;

  assign clr_busy    = (state == CLEAR);
  assign pending_cnt = cnt;

  assign alloc_ok = !clr_busy && (!pending[alloc_addr] || (wr_en && (wr_addr == alloc_addr)));
  assign wr_go    = wr_en && !clr_busy && !(ZR && (wr_addr == '0));
  assign alloc_go = alloc_en && alloc_ok && !(ZR && (alloc_addr == '0));

  // Population delta: count only real 0->1 and 1->0 transitions of pending bits;
  // a write and alloc on the same register leave the bit set.
  assign inc = alloc_go && !pending[alloc_addr];
  assign dec = wr_go && pending[wr_addr] && !(alloc_go && (alloc_addr == wr_addr));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (idx == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        regs[idx]    <= '0;
        pending[idx] <= 1'b0;
        idx          <= idx + ADDR_W'(1);
        if (idx == '1) cnt <= '0;
      end else begin
        if (clr_req) idx <= '0;
        if (wr_go) begin
          regs[wr_addr]    <= wr_data;
          pending[wr_addr] <= 1'b0;
        end
        if (alloc_go) pending[alloc_addr] <= 1'b1;
        cnt <= cnt + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
      end
    end
  end

  always_comb begin
    rd_data1  = regs[rd_addr1];
    rd_ready1 = !clr_busy && !pending[rd_addr1];
    if (ZR && (rd_addr1 == '0)) begin
      rd_data1  = '0;
      rd_ready1 = !clr_busy;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && !clr_busy && (wr_addr == rd_addr1)) begin
      rd_data1  = wr_data;
      rd_ready1 = 1'b1;
    end
`endif
  end

  always_comb begin
    rd_data2  = regs[rd_addr2];
    rd_ready2 = !clr_busy && !pending[rd_addr2];
    if (ZR && (rd_addr2 == '0)) begin
      rd_data2  = '0;
      rd_ready2 = !clr_busy;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && !clr_busy && (wr_addr == rd_addr2)) begin
      rd_data2  = wr_data;
      rd_ready2 = 1'b1;
    end
`endif
  end

endmodule
